// File: rtl/sentinel_pkg.sv
// Shared types and default sizing for the sentinel multiply-op dispatcher.
package sentinel_pkg;

  localparam int unsigned SENTINEL_WIDTH = 256;
  localparam int unsigned SENTINEL_TAG_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } dispatch_state_t;

endpackage

// File: rtl/sentinel_job_fifo.sv
// Power-of-two job FIFO; head reads as zero while empty so downstream operands stay quiet.
module sentinel_job_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] data_in,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/sentinel_mulop_dispatcher.sv
// Queues multiply jobs and runs them one at a time through an external multiplier.
// Optional WAIT watchdog enabled by defining SENTINEL_DISPATCH_TIMEOUT_EN.
module sentinel_mulop_dispatcher
  import sentinel_pkg::*;
#(
  parameter int unsigned WIDTH          = SENTINEL_WIDTH,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TAG_W          = SENTINEL_TAG_W,
  parameter int unsigned TIMEOUT_CYCLES = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             acc_start,
  output logic [WIDTH-1:0] acc_a,
  output logic [WIDTH-1:0] acc_b,
  input  logic [WIDTH-1:0] acc_result,
  input  logic             acc_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_timeout,
  output logic             busy
);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a;
  } job_t;

  localparam int unsigned JOB_W = 2 * WIDTH + TAG_W;

  if (DEPTH < 2 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("sentinel_mulop_dispatcher: DEPTH must be >= 2 and TIMEOUT_CYCLES > 0");
  end

  dispatch_state_t state, state_next;
  job_t            in_job, head;
  logic            push, pop, full, empty;
  logic            done_hit, expire;

  assign in_job = '{tag: in_tag, b: in_b, a: in_a};
  assign push   = in_valid && !full;

  sentinel_job_fifo #(
    .W     (JOB_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .data_in (in_job),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  assign in_ready = !full;
  assign acc_a    = head.a;
  assign acc_b    = head.b;
  assign busy     = !empty || (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state; the head is popped on the cycle the result (or timeout) is captured.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    done_hit   = 1'b0;
    case (state)
      IDLE:  if (!empty) state_next = ISSUE;
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (acc_done) begin
          done_hit   = 1'b1;
          pop        = 1'b1;
          state_next = HOLD;
        end else if (expire) begin
          pop        = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef SENTINEL_DISPATCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] wait_cnt;

  // Counts completed WAIT cycles; cleared in ISSUE so every job starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              wait_cnt <= '0;
    else if (state == ISSUE) wait_cnt <= '0;
    else if (state == WAIT)  wait_cnt <= wait_cnt + CNT_W'(1);
  end

  assign expire = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   out_timeout <= 1'b0;
    else if (pop) out_timeout <= !done_hit;
  end
`else
  assign expire      = 1'b0;
  assign out_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_start  <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else begin
      acc_start <= (state_next == ISSUE);
      out_valid <= (state_next == HOLD);
      if (pop) begin
        out_result <= done_hit ? acc_result : '0;
        out_tag    <= head.tag;
      end
    end
  end

endmodule

// File: tb/tb_sentinel_mulop_dispatcher.sv
// Directed self-checking bench for sentinel_mulop_dispatcher (default parameters).
`timescale 1ns/1ps
module tb_sentinel_mulop_dispatcher;

  localparam int unsigned WIDTH = 256;
  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [TAG_W-1:0] in_tag;
  logic             acc_start;
  logic [WIDTH-1:0] acc_a, acc_b;
  logic [WIDTH-1:0] acc_result;
  logic             acc_done;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_timeout;
  logic             busy;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  sentinel_mulop_dispatcher #(
    .WIDTH(WIDTH), .DEPTH(4), .TAG_W(TAG_W), .TIMEOUT_CYCLES(128)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .acc_start(acc_start), .acc_a(acc_a), .acc_b(acc_b),
    .acc_result(acc_result), .acc_done(acc_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_timeout(out_timeout),
    .busy(busy)
  );

  // Counts acc_start pulses; a pulse lasts one full cycle so one negedge sees it.
  always @(negedge clk) begin
    if (!rst_n)         start_cnt <= 0;
    else if (acc_start) start_cnt <= start_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int budget);
    int i;
    i = 0;
    while (acc_start !== 1'b1 && i < budget) begin
      tick;
      i++;
    end
    check("issue_seen", WIDTH'(acc_start), WIDTH'(1));
  endtask

  task automatic push_job(input int t, input int a);
    in_valid = 1'b1;
    in_tag   = TAG_W'(t);
    in_a     = WIDTH'(a);
    in_b     = WIDTH'(a + 1);
    tick;
    in_valid = 1'b0;
  endtask

  // Runs the job at the head: issue, multiplier reply, optional backpressure, release.
  task automatic complete_job(input int res, input int tag, input int exp_a, input int hold);
    int snap;
    wait_start(20);
    check("acc_a", acc_a, WIDTH'(exp_a));
    check("acc_b", acc_b, WIDTH'(exp_a + 1));
    repeat (3) tick;
    acc_result = WIDTH'(res);
    acc_done   = 1'b1;
    tick;
    acc_done   = 1'b0;
    check("out_valid", WIDTH'(out_valid), WIDTH'(1));
    check("out_tag", WIDTH'(out_tag), WIDTH'(tag));
    check("out_result", out_result, WIDTH'(res));
    check("out_timeout", WIDTH'(out_timeout), WIDTH'(0));
    if (hold > 0) begin
      snap = start_cnt;
      repeat (hold) begin
        tick;
        check("hold_valid", WIDTH'(out_valid), WIDTH'(1));
        check("hold_result", out_result, WIDTH'(res));
        check("hold_tag", WIDTH'(out_tag), WIDTH'(tag));
      end
      check("hold_no_issue", WIDTH'(start_cnt), WIDTH'(snap));
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("released", WIDTH'(out_valid), WIDTH'(0));
    if (hold > 0) begin
      check("gap_idle", WIDTH'(acc_start), WIDTH'(0));
      tick;
      check("gap_issue", WIDTH'(acc_start), WIDTH'(1));
    end
  endtask

  initial begin
    int base;
    logic seen_valid, seen_start;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    acc_result = '0; acc_done = 1'b0; out_ready = 1'b0;
    repeat (3) tick;

    // Reset values
    check("rst_acc_start", WIDTH'(acc_start), WIDTH'(0));
    check("rst_out_valid", WIDTH'(out_valid), WIDTH'(0));
    check("rst_out_result", out_result, WIDTH'(0));
    check("rst_out_tag", WIDTH'(out_tag), WIDTH'(0));
    check("rst_out_timeout", WIDTH'(out_timeout), WIDTH'(0));
    check("rst_busy", WIDTH'(busy), WIDTH'(0));
    check("rst_acc_a", acc_a, WIDTH'(0));
    rst_n = 1'b1;
    tick;
    check("rst_in_ready", WIDTH'(in_ready), WIDTH'(1));

    // Single job with exact issue latency and 66-cycle multiplier
    in_valid = 1'b1; in_a = WIDTH'(5); in_b = WIDTH'(3); in_tag = TAG_W'(2);
    check("single_in_ready", WIDTH'(in_ready), WIDTH'(1));
    tick;
    in_valid = 1'b0;
    check("single_idle", WIDTH'(acc_start), WIDTH'(0));
    check("single_busy", WIDTH'(busy), WIDTH'(1));
    tick;
    check("single_start", WIDTH'(acc_start), WIDTH'(1));
    check("single_a", acc_a, WIDTH'(5));
    check("single_b", acc_b, WIDTH'(3));
    tick;
    check("single_start_drop", WIDTH'(acc_start), WIDTH'(0));
    repeat (64) tick;
    check("single_a_stable", acc_a, WIDTH'(5));
    acc_result = WIDTH'(12'hABC); acc_done = 1'b1;
    tick;
    acc_done = 1'b0;
    check("single_valid", WIDTH'(out_valid), WIDTH'(1));
    check("single_result", out_result, WIDTH'(12'hABC));
    check("single_tag", WIDTH'(out_tag), WIDTH'(2));
    check("single_timeout", WIDTH'(out_timeout), WIDTH'(0));
    check("single_one_start", WIDTH'(start_cnt), WIDTH'(1));
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("single_done_valid", WIDTH'(out_valid), WIDTH'(0));
    check("single_idle_busy", WIDTH'(busy), WIDTH'(0));

    // Stray acc_done in IDLE is ignored
    acc_result = WIDTH'(12'h777); acc_done = 1'b1;
    tick;
    acc_done = 1'b0;
    tick;
    check("stray_valid", WIDTH'(out_valid), WIDTH'(0));
    check("stray_result", out_result, WIDTH'(12'hABC));

    // Fill: four accepted with the multiplier stalled, fifth waits for the first pop
    base = start_cnt;
    for (int k = 0; k < 4; k++) begin
      check("fill_ready", WIDTH'(in_ready), WIDTH'(1));
      in_valid = 1'b1; in_tag = TAG_W'(k); in_a = WIDTH'(16 + k); in_b = WIDTH'(17 + k);
      tick;
    end
    in_tag = TAG_W'(4); in_a = WIDTH'(20); in_b = WIDTH'(21);
    check("fill_full", WIDTH'(in_ready), WIDTH'(0));
    repeat (5) tick;
    check("fill_still_full", WIDTH'(in_ready), WIDTH'(0));
    check("fill_one_issue", WIDTH'(start_cnt), WIDTH'(base + 1));
    check("fill_head_a", acc_a, WIDTH'(16));
    acc_result = WIDTH'(256); acc_done = 1'b1;
    tick;
    acc_done = 1'b0;
    check("fill_ready_after_pop", WIDTH'(in_ready), WIDTH'(1));
    check("fill_out_tag0", WIDTH'(out_tag), WIDTH'(0));
    check("fill_out_res0", out_result, WIDTH'(256));
    tick;
    in_valid = 1'b0;
    check("fill_full_again", WIDTH'(in_ready), WIDTH'(0));
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    for (int k = 1; k < 5; k++) complete_job(256 + k, k, 16 + k, 0);

    // Push on the pop cycle with occupancy 3, then backpressure on the next result
    push_job(5, 32 + 5);
    push_job(6, 32 + 6);
    push_job(7, 32 + 7);
    repeat (2) tick;
    acc_result = WIDTH'(517); acc_done = 1'b1;
    in_valid = 1'b1; in_tag = TAG_W'(8); in_a = WIDTH'(40); in_b = WIDTH'(41);
    check("occ_pop_ready", WIDTH'(in_ready), WIDTH'(1));
    tick;
    acc_done = 1'b0;
    check("occ_stays3", WIDTH'(in_ready), WIDTH'(1));
    in_tag = TAG_W'(9); in_a = WIDTH'(41); in_b = WIDTH'(42);
    tick;
    in_valid = 1'b0;
    check("occ_now_full", WIDTH'(in_ready), WIDTH'(0));
    check("occ_out_tag5", WIDTH'(out_tag), WIDTH'(5));
    check("occ_out_res5", out_result, WIDTH'(517));
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    complete_job(518, 6, 38, 20);
    complete_job(519, 7, 39, 0);
    complete_job(520, 8, 40, 0);
    complete_job(521, 9, 41, 0);
    check("drained_busy", WIDTH'(busy), WIDTH'(0));

    // Reset in WAIT with three jobs queued behind the in-flight one
    push_job(10, 48);
    push_job(11, 49);
    push_job(12, 50);
    push_job(13, 51);
    repeat (3) tick;
    check("pre_rst_busy", WIDTH'(busy), WIDTH'(1));
    rst_n = 1'b0;
    tick;
    check("mid_rst_acc_start", WIDTH'(acc_start), WIDTH'(0));
    check("mid_rst_out_valid", WIDTH'(out_valid), WIDTH'(0));
    check("mid_rst_out_result", out_result, WIDTH'(0));
    check("mid_rst_out_tag", WIDTH'(out_tag), WIDTH'(0));
    check("mid_rst_busy", WIDTH'(busy), WIDTH'(0));
    check("mid_rst_acc_a", acc_a, WIDTH'(0));
    rst_n = 1'b1;
    seen_valid = 1'b0; seen_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      acc_done = (i == 5);
      acc_result = WIDTH'(99);
      tick;
      seen_valid |= out_valid;
      seen_start |= acc_start;
    end
    acc_done = 1'b0;
    check("post_rst_no_valid", WIDTH'(seen_valid), WIDTH'(0));
    check("post_rst_no_start", WIDTH'(seen_start), WIDTH'(0));
    check("post_rst_busy", WIDTH'(busy), WIDTH'(0));
    check("post_rst_ready", WIDTH'(in_ready), WIDTH'(1));

`ifdef SENTINEL_DISPATCH_TIMEOUT_EN
    // Watchdog: no acc_done, timeout result exactly 128 cycles into WAIT
    push_job(3, 64);
    wait_start(20);
    repeat (128) tick;
    check("to_not_yet", WIDTH'(out_valid), WIDTH'(0));
    tick;
    check("to_valid", WIDTH'(out_valid), WIDTH'(1));
    check("to_flag", WIDTH'(out_timeout), WIDTH'(1));
    check("to_result", out_result, WIDTH'(0));
    check("to_tag", WIDTH'(out_tag), WIDTH'(3));
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    push_job(4, 68);
    complete_job(1028, 4, 68, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
